// File: rtl/serial_adder_ctrl_if.sv
// Requester-side handshake and operand/result bundle
// for the bit-serial adder sequencer.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;

  modport master (
    output start, A, B,
    input  busy, done, S, Cout
  );

  modport slave (
    input  start, A, B,
    output busy, done, S, Cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell (two half
// adders) walks the operands LSB first, one bit per clock.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input logic                clk,
  input logic                rst,
  serial_adder_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic s1;
  logic c1;
  logic sum_bit;
  logic c2;
  logic carry_nxt;

  half_adder u_ha0 (
    .a (op_a[0]),
    .b (op_b[0]),
    .s (s1),
    .c (c1)
  );

  half_adder u_ha1 (
    .a (s1),
    .b (carry),
    .s (sum_bit),
    .c (c2)
  );

  assign carry_nxt = c1 | c2;

  logic [WIDTH-1:0] acc_nxt;
  logic             last;
  logic             accept;

  assign acc_nxt = {sum_bit, acc[WIDTH-1:1]};
  assign last    = (cnt == CW'(WIDTH - 1));
  // DONE accepts like IDLE so requests can run back to back
  assign accept  = bus.start &&
                   (state == IDLE || state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.S    <= '0;
      bus.Cout <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (accept) begin
            op_a     <= bus.A;
            op_b     <= bus.B;
            acc      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= carry_nxt;
          cnt   <= cnt + 1'b1;
          if (last) begin
            bus.S    <= acc_nxt;
            bus.Cout <= carry_nxt;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule
